fab_bitstream_loader_checker: RTL

- Synthesizable successor to the bench-level bitstream load and golden-compare sequence, for emulation and on-chip self-test.
- Packs a byte stream into configuration words and drives the fabric self-write port with programmable setup and gap timing.
- After loading, waits a settle period, then compares the fabric I/O against a golden model for a fixed window.
- Reports a sticky error flag, an error count, and the index of the first mismatching cycle.

---
 rtl/fab_bitstream_loader_checker_if.sv | 21 ++
 rtl/fab_bitstream_loader_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fab_bitstream_loader_checker_if.sv
// Byte-stream input and fabric self-write output of the bitstream loader.
// master = loader side, slave = byte source / fabric side.
interface fab_bitstream_loader_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic [DATA_WIDTH-1:0] SelfWriteData;
    logic                  SelfWriteStrobe;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, SelfWriteData, SelfWriteStrobe
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, SelfWriteData, SelfWriteStrobe
    );
endinterface

// File: rtl/fab_bitstream_loader_checker.sv
// Packs a byte stream into configuration words, strobes them into the fabric,
// then compares fabric I/O against a golden model over a fixed window.
module fab_bitstream_loader_checker #(
    parameter int DATA_WIDTH    = 32,
    parameter int IO_WIDTH      = 24,
    parameter int MAX_WORDS     = 4096,
    parameter int SETUP_CYCLES  = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 100,
    parameter int CHECK_CYCLES  = 100,
    parameter int ERRW          = 16,
    localparam int WCW = $clog2(MAX_WORDS + 1),
    localparam int FEW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WCW-1:0]       word_count,
    fab_bitstream_loader_checker_if.master bs,
    input  logic [IO_WIDTH-1:0]  fab_io,
    input  logic [IO_WIDTH-1:0]  fab_t,
    input  logic [IO_WIDTH-1:0]  gold_io,
    input  logic [IO_WIDTH-1:0]  gold_t,
    input  logic [IO_WIDTH-1:0]  cmp_mask,
    output logic                 busy,
    output logic                 load_done,
    output logic                 done,
    output logic                 mismatch,
    output logic [ERRW-1:0]      err_count,
    output logic [FEW-1:0]       first_err
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int BCW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int TMAX_A = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int TMAX_B = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    localparam logic [BCW-1:0] BYTE_LAST   = BCW'(NB - 1);
    localparam logic [TW-1:0]  SETUP_LAST  = TW'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [TW-1:0]  GAP_LAST    = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0]  SETTLE_LAST = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0]  CHECK_LAST  = TW'((CHECK_CYCLES > 0) ? CHECK_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, GATHER, SETUP, STROBE, GAP, SETTLE, CHECK, DONE
    } state_e;

    // A zero settle period skips straight into the compare window.
    localparam state_e POST_LOAD = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [WCW-1:0]        rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  load_done_q, load_done_d;
    logic                  mismatch_q, mismatch_d;
    logic [ERRW-1:0]       err_q, err_d;
    logic [FEW-1:0]        first_q, first_d;
    logic [IO_WIDTH-1:0]   diff;

    assign diff = ((fab_io ^ gold_io) | (fab_t ^ gold_t)) & cmp_mask;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bcnt_q      <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            load_done_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bcnt_q      <= bcnt_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            load_done_q <= load_done_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bcnt_d      = bcnt_q;
        rem_d       = rem_q;
        data_d      = data_q;
        load_done_d = load_done_q;
        mismatch_d  = mismatch_q;
        err_d       = err_q;
        first_d     = first_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rem_d       = word_count;
                    timer_d     = '0;
                    bcnt_d      = '0;
                    load_done_d = 1'b0;
                    mismatch_d  = 1'b0;
                    err_d       = '0;
                    first_d     = '0;
                    state_d     = (word_count == '0) ? POST_LOAD : GATHER;
                end
            end
            GATHER: begin
                if (bs.byte_valid) begin
                    // Shift left so the first byte of a word ends up in the MSBs.
                    data_d = DATA_WIDTH'({data_q, bs.byte_data});
                    if (bcnt_q == BYTE_LAST) begin
                        bcnt_d  = '0;
                        timer_d = '0;
                        state_d = SETUP;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            SETUP: begin
                if (timer_q == SETUP_LAST) begin
                    timer_d = '0;
                    state_d = STROBE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STROBE: begin
                rem_d   = rem_q - 1'b1;
                timer_d = '0;
                if (rem_q == WCW'(1)) begin
                    load_done_d = 1'b1;
                    state_d     = POST_LOAD;
                end else begin
                    state_d = (GAP_CYCLES > 0) ? GAP : GATHER;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = GATHER;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if (diff != '0) begin
                    if (err_q != {ERRW{1'b1}}) err_d = err_q + 1'b1;
                    if (!mismatch_q) first_d = FEW'(timer_q);
                    mismatch_d = 1'b1;
                end
                if (timer_q == CHECK_LAST) begin
                    timer_d = '0;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bs.byte_ready      = (state_q == GATHER);
    assign bs.SelfWriteStrobe = (state_q == STROBE);
    assign bs.SelfWriteData   = data_q;
    assign busy               = (state_q != IDLE) && (state_q != DONE);
    assign done               = (state_q == DONE);
    assign load_done          = load_done_q;
    assign mismatch           = mismatch_q;
    assign err_count          = err_q;
    assign first_err          = first_q;
endmodule
